// File: rtl/axistream_forwarder_pkg.sv
// axistream_forwarder_pkg: shared FSM encodings and width helpers for the packet forwarder
package axistream_forwarder_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLAIM  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  function automatic int fwd_bytes(input int data_width);
    return data_width / 8;
  endfunction
  function automatic int fwd_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/axistream_forwarder_if.sv
// axistream_forwarder_if: claim handshake, packet-memory read port and AXI-Stream master bundle
interface axistream_forwarder_if
  import axistream_forwarder_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 8,
  parameter int PW = 32
) ();
  logic                    rdy_for_fwd;
  logic                    rdy_for_fwd_ack;
  logic [PW-1:0]           fwd_byte_len;
  logic [AW-1:0]           fwd_addr;
  logic                    fwd_rd_en;
  logic [DW-1:0]           fwd_rd_data;
  logic                    fwd_rd_data_vld;
  logic                    fwd_done;
  logic [DW-1:0]           m_axis_tdata;
  logic [fwd_bytes(DW)-1:0] m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  modport master (
    input  rdy_for_fwd, fwd_byte_len, fwd_rd_data, fwd_rd_data_vld, m_axis_tready,
    output rdy_for_fwd_ack, fwd_addr, fwd_rd_en, fwd_done,
           m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
  modport slave (
    output rdy_for_fwd, fwd_byte_len, fwd_rd_data, fwd_rd_data_vld, m_axis_tready,
    input  rdy_for_fwd_ack, fwd_addr, fwd_rd_en, fwd_done,
           m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/axistream_forwarder_fifo.sv
// fwd_fifo: small register FIFO whose head entry drives the stream outputs directly
module fwd_fifo
  import axistream_forwarder_pkg::*;
#(
  parameter int W     = 73,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = fwd_count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign do_pop  = pop && cnt_q != '0;
  assign do_push = push && cnt_q != CW'(DEPTH);
  assign dout    = mem_q[rp_q];
  assign count   = cnt_q;
  assign empty   = cnt_q == '0;
  // storage and pointers; cleared on reset so the head reads as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wp_q] <= din;
      wp_q  <= wp_q + PW'(do_push);
      rp_q  <= rp_q + PW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/axistream_forwarder.sv
// axistream_forwarder: claims a packet, reads it from packet memory and streams it out as AXI-Stream
module axistream_forwarder
  import axistream_forwarder_pkg::*;
#(
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int PLEN_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input logic clk,
  input logic rst,
  axistream_forwarder_if.master bus
);
  localparam int BYTES = fwd_bytes(SN_FWD_DATA_WIDTH);
  localparam int WW    = PLEN_WIDTH + 1;
  localparam int CW    = fwd_count_width(FIFO_DEPTH);
  localparam int CW1   = CW + 1;
  localparam int EW    = SN_FWD_DATA_WIDTH + BYTES + 1;
  logic [1:0]                   state_q, state_d;
  logic [PLEN_WIDTH-1:0]        len_q, len_d;
  logic [WW-1:0]                words_q, words_d;
  logic [WW-1:0]                issued_q, issued_d;
  logic [WW-1:0]                recv_q, recv_d;
  logic [CW-1:0]                inflight_q, inflight_d;
  logic                         cool_q, cool_d;
  logic                         ack_q, ack_d;
  logic                         done_q, done_d;
  logic                         rd_en_q, rd_en_d;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [EW-1:0]                head;
  logic [CW-1:0]                fifo_count;
  logic                         fifo_empty, push, pop, head_last, is_last, issue;
  logic [WW-1:0]                words_calc, words_cur;
  logic [CW-1:0]                inflight_after;
  logic [CW:0]                  credits;
  logic [PLEN_WIDTH-1:0]        rem;
  logic [BYTES-1:0]             keep_w;
  assign words_calc     = (WW'(bus.fwd_byte_len) + WW'(BYTES - 1)) / WW'(BYTES);
  assign words_cur      = state_q == S_CLAIM ? words_calc : words_q;
  assign push           = bus.fwd_rd_data_vld && inflight_q != '0 && state_q == S_STREAM;
  assign pop            = !fifo_empty && bus.m_axis_tready;
  assign head_last      = head[0];
  assign is_last        = recv_q == words_q - WW'(1);
  assign rem            = len_q % PLEN_WIDTH'(BYTES);
  assign keep_w         = is_last && rem != '0 ? ~({BYTES{1'b1}} >> rem) : '1;
  assign inflight_after = inflight_q - CW'(push);
  // credits count every word that will occupy a FIFO slot: stored words plus reads still in flight
  assign credits        = CW1'(fifo_count) + CW1'(push) - CW1'(pop) + CW1'(inflight_after);
  assign issue          = (state_q == S_CLAIM || state_q == S_STREAM) && issued_q < words_cur &&
                          credits < CW1'(FIFO_DEPTH);
  assign bus.rdy_for_fwd_ack = ack_q;
  assign bus.fwd_done        = done_q;
  assign bus.fwd_rd_en       = rd_en_q;
  assign bus.fwd_addr        = addr_q;
  assign bus.m_axis_tvalid   = !fifo_empty;
  assign {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast} = head;
  fwd_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.fwd_rd_data, keep_w, is_last}),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );
  // claim/stream/done sequencing plus read issue and return bookkeeping
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    issued_d   = issued_q + WW'(issue);
    recv_d     = recv_q + WW'(push);
    inflight_d = inflight_after + CW'(issue);
    rd_en_d    = issue;
    addr_d     = issue ? issued_q[SN_FWD_ADDR_WIDTH-1:0] : addr_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    cool_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        issued_d   = '0;
        recv_d     = '0;
        inflight_d = '0;
        state_d    = bus.rdy_for_fwd && !cool_q ? S_CLAIM : S_IDLE;
        ack_d      = bus.rdy_for_fwd && !cool_q;
      end
      S_CLAIM: begin
        len_d   = bus.fwd_byte_len;
        words_d = words_calc;
        state_d = words_calc == '0 ? S_DONE : S_STREAM;
        done_d  = words_calc == '0;
      end
      S_STREAM: begin
        state_d = pop && head_last ? S_DONE : S_STREAM;
        done_d  = pop && head_last;
      end
      default: begin
        state_d = S_IDLE;
        cool_d  = 1'b1;
      end
    endcase
  end
  // state and registered outputs; reset abandons any packet in progress without a done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      recv_q     <= '0;
      inflight_q <= '0;
      cool_q     <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      issued_q   <= issued_d;
      recv_q     <= recv_d;
      inflight_q <= inflight_d;
      cool_q     <= cool_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
    end
  end
endmodule

// File: tb/tb_axistream_forwarder.sv
// tb_axistream_forwarder: directed packets against a latency-modelled memory and a back-pressuring sink
module tb_axistream_forwarder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axistream_forwarder_if #(.DW(64), .AW(8), .PW(32)) bus ();
  axistream_forwarder #(
    .SN_FWD_DATA_WIDTH(64), .SN_FWD_ADDR_WIDTH(8), .PLEN_WIDTH(32), .FIFO_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit tog = 1'b0;
  int pend_due[$];
  int pend_addr[$];
  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  logic        bl[$];
  int bcyc[$];
  int addrs[$];
  int rd_cyc[$];
  int ack_cyc[$];
  int done_cyc[$];
  int tv_cnt, rd_tot, hs_tot, max_cred;
  bit prev_stall = 1'b0;
  logic [63:0] pdata;
  logic [7:0]  pkeep;
  logic        plast;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] mem_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {24'hABCDEF, b, 24'h135790, ~b};
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic clear();
    bd.delete(); bk.delete(); bl.delete(); bcyc.delete();
    addrs.delete(); rd_cyc.delete(); ack_cyc.delete(); done_cyc.delete();
    tv_cnt = 0; rd_tot = 0; hs_tot = 0; max_cred = 0;
  endtask
  // memory model, sink and protocol monitor, all acting mid-cycle on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (bus.rdy_for_fwd_ack) ack_cyc.push_back(cyc);
    if (bus.fwd_done) done_cyc.push_back(cyc);
    if (!rst) begin
      pend_due.delete();
      pend_addr.delete();
      bus.fwd_rd_data_vld = 1'b0;
      bus.fwd_rd_data = '0;
      bus.m_axis_tready = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.m_axis_tvalid, 1);
        check("hold_data", bus.m_axis_tdata, pdata);
        check("hold_keep", bus.m_axis_tkeep, pkeep);
        check("hold_last", bus.m_axis_tlast, plast);
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        bus.fwd_rd_data_vld = 1'b1;
        bus.fwd_rd_data = mem_word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        bus.fwd_rd_data_vld = 1'b0;
        bus.fwd_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (bus.fwd_rd_en) begin
        addrs.push_back(int'(bus.fwd_addr));
        rd_cyc.push_back(cyc);
        pend_due.push_back(cyc + lat);
        pend_addr.push_back(int'(bus.fwd_addr));
        rd_tot++;
      end
      if (rd_tot - hs_tot > max_cred) max_cred = rd_tot - hs_tot;
      bus.m_axis_tready = tog ? ~bus.m_axis_tready : 1'b1;
      if (bus.m_axis_tvalid) tv_cnt++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        bd.push_back(bus.m_axis_tdata);
        bk.push_back(bus.m_axis_tkeep);
        bl.push_back(bus.m_axis_tlast);
        bcyc.push_back(cyc);
        hs_tot++;
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      pdata = bus.m_axis_tdata;
      pkeep = bus.m_axis_tkeep;
      plast = bus.m_axis_tlast;
    end
  end
  task automatic check_reset(input string p);
    check({p, "_ack"}, bus.rdy_for_fwd_ack, 0);
    check({p, "_rd_en"}, bus.fwd_rd_en, 0);
    check({p, "_done"}, bus.fwd_done, 0);
    check({p, "_tvalid"}, bus.m_axis_tvalid, 0);
    check({p, "_tlast"}, bus.m_axis_tlast, 0);
    check({p, "_addr"}, bus.fwd_addr, 0);
    check({p, "_tdata"}, bus.m_axis_tdata, 0);
    check({p, "_tkeep"}, bus.m_axis_tkeep, 0);
  endtask
  task automatic run_pkt(input string tag, input int len, input int lat_v, input bit tog_v,
                         input int nb, input logic [7:0] lkeep);
    int c0;
    clear();
    lat = lat_v;
    tog = tog_v;
    bus.fwd_byte_len = len;
    bus.rdy_for_fwd = 1'b1;
    c0 = cyc;
    step();
    bus.rdy_for_fwd = 1'b0;
    check({tag, "_ack_lat"}, ack_cyc.size() == 1 ? ack_cyc[0] - c0 : -1, 1);
    for (int i = 0; i < 400 && done_cyc.size() == 0; i++) step();
    check({tag, "_done"}, done_cyc.size(), 1);
    repeat (3) step();
    tog = 1'b0;
    check({tag, "_nbeats"}, bd.size(), nb);
    check({tag, "_nreads"}, addrs.size(), nb);
    for (int i = 0; i < nb; i++) begin
      if (i < bd.size()) begin
        check($sformatf("%s_data%0d", tag, i), bd[i], mem_word(i));
        check($sformatf("%s_keep%0d", tag, i), bk[i], i == nb - 1 ? lkeep : 8'hFF);
        check($sformatf("%s_last%0d", tag, i), bl[i], i == nb - 1);
      end
      if (i < addrs.size()) check($sformatf("%s_addr%0d", tag, i), addrs[i], i);
    end
    if (nb > 0) begin
      check({tag, "_rd_lat"}, rd_cyc.size() > 0 && ack_cyc.size() > 0 ? rd_cyc[0] - ack_cyc[0] : -1, 1);
      check({tag, "_done_lat"}, bcyc.size() > 0 && done_cyc.size() > 0 ?
            done_cyc[0] - bcyc[bcyc.size() - 1] : -1, 1);
    end else begin
      check({tag, "_no_tvalid"}, tv_cnt, 0);
      check({tag, "_no_rd_en"}, rd_tot, 0);
      check({tag, "_done_lat"}, done_cyc.size() > 0 && ack_cyc.size() > 0 ?
            done_cyc[0] - ack_cyc[0] : -1, 1);
    end
  endtask
  initial begin
    bus.rdy_for_fwd = 1'b0;
    bus.fwd_byte_len = '0;
    #2 rst = 1'b0;
    #1 check_reset("por");
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    run_pkt("full16", 16, 1, 1'b0, 2, 8'hFF);
    run_pkt("part13", 13, 1, 1'b0, 2, 8'hF8);
    run_pkt("zero", 0, 1, 1'b0, 0, 8'h00);
    run_pkt("bp64", 64, 2, 1'b1, 8, 8'hFF);
    check("bp64_credits", max_cred <= 4, 1);
    clear();
    lat = 1;
    bus.fwd_byte_len = 64;
    bus.rdy_for_fwd = 1'b1;
    step();
    bus.rdy_for_fwd = 1'b0;
    for (int i = 0; i < 100 && bd.size() < 3; i++) step();
    step();
    check("mid_beats", bd.size() >= 3, 1);
    rst = 1'b0;
    #1 check_reset("mid");
    repeat (3) step();
    check("mid_no_done", done_cyc.size(), 0);
    rst = 1'b1;
    repeat (2) step();
    run_pkt("after_rst", 8, 1, 1'b0, 1, 8'hFF);
    clear();
    bus.fwd_byte_len = 16;
    bus.rdy_for_fwd = 1'b1;
    for (int i = 0; i < 300 && ack_cyc.size() < 2; i++) step();
    bus.rdy_for_fwd = 1'b0;
    check("b2b_acks", ack_cyc.size(), 2);
    check("b2b_gap", ack_cyc.size() == 2 && done_cyc.size() >= 1 && ack_cyc[1] - done_cyc[0] >= 2, 1);
    for (int i = 0; i < 300 && done_cyc.size() < 2; i++) step();
    check("b2b_dones", done_cyc.size(), 2);
    check("b2b_beats", bd.size(), 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
